// File: rtl/adder_checker_64.sv
// Stimulus driver and result checker for the 64-bit adder labs: drives A/B/C_in
// to both adders, holds them for a settle window, then compares and tallies errors.
module adder_checker_64 #(
  parameter int          WIDTH         = 64,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          NUM_VECTORS   = 256,
  parameter logic [63:0] SEED          = 64'hACE1_0000_0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             C_in,
  input  logic [WIDTH-1:0] Sum_dut,
  input  logic             C_out_dut,
  input  logic [WIDTH-1:0] Sum_verify,
  input  logic             C_out_verify,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count,
  output logic [15:0]      first_fail_idx
);

  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
  localparam int          SCW       = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_COMPARE, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SCW-1:0]   settle_cnt;
  logic [63:0]      lfsr, lfsr_nxt, lfsr_rot;
  logic             mismatch, last_vec, settle_end;
  logic [15:0]      err_nxt;

  // Galois right-shift, taps 64,63,61,60
  assign lfsr_nxt   = lfsr[0] ? ({1'b0, lfsr[63:1]} ^ LFSR_MASK) : {1'b0, lfsr[63:1]};
  assign lfsr_rot   = {lfsr[31:0], lfsr[63:32]};
  assign mismatch   = (Sum_dut != Sum_verify) || (C_out_dut != C_out_verify);
  assign last_vec   = (32'(vec_count) + 32'd1) >= 32'(NUM_VECTORS);
  assign settle_end = (settle_cnt == SCW'(SETTLE_CYCLES - 1));
  assign err_nxt    = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
      S_DRIVE:        state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_end) state_nxt = S_COMPARE;
      S_COMPARE:      state_nxt = last_vec ? S_DONE : S_DRIVE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A              <= '0;
      B              <= '0;
      C_in           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      vec_count      <= '0;
      first_fail_idx <= 16'hFFFF;
      lfsr           <= SEED;
      settle_cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count      <= '0;
            vec_count      <= '0;
            first_fail_idx <= 16'hFFFF;
            lfsr           <= SEED;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
          end
        end
        S_DRIVE: begin
          settle_cnt <= '0;
          if (vec_count == 16'd0) begin
            A    <= '0;
            B    <= '0;
            C_in <= 1'b0;
          end else if (vec_count == 16'd1) begin
            A    <= '1;
            B    <= '0;
            C_in <= 1'b1;
          end else begin
            A    <= lfsr[WIDTH-1:0];
            B    <= lfsr_rot[WIDTH-1:0];
            C_in <= lfsr[0];
            lfsr <= lfsr_nxt;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + SCW'(1);
        S_COMPARE: begin
          vec_count <= vec_count + 16'd1;
          err_count <= err_nxt;
          if (mismatch && first_fail_idx == 16'hFFFF) first_fail_idx <= vec_count;
          if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_nxt == 16'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_checker_64.sv
// Bench for adder_checker_64: behavioural adders with injectable faults, expected
// vectors/results queued at stimulus time and popped by a monitor on DUT events.
module tb_adder_checker_64;

  localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;
  localparam logic [63:0] MASK = 64'hD800_0000_0000_0000;

  typedef struct packed { logic [63:0] a; logic [63:0] b; logic c; } vec_t;
  typedef struct packed { logic [15:0] err; logic [15:0] vc; logic [15:0] ffi; logic pass; } fin_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  int   fault = 0;
  int   checks = 0, errors = 0;

  vec_t exp_q[$];
  fin_t fin_q[$];
  fin_t fin2_q[$];

  // main instance (defaults)
  logic [63:0] a, b, sum_ref, sum_dut;
  logic        cin, co_ref, co_dut, busy, done, pass;
  logic [15:0] err_count, vec_count, ffi;
  // small instance, carry-out inverted
  logic [63:0] a2, b2, sum2_ref;
  logic        cin2, co2_ref, busy2, done2, pass2;
  logic [15:0] err2, vc2, ffi2;

  always #5 clk = ~clk;

  assign {co_ref, sum_ref}   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
  assign sum_dut             = (fault == 1) ? (sum_ref & ~64'h20) : sum_ref;
  assign co_dut              = co_ref;
  assign {co2_ref, sum2_ref} = {1'b0, a2} + {1'b0, b2} + {64'd0, cin2};

  adder_checker_64 u_dut (
    .clk(clk), .rst(rst), .start(start),
    .A(a), .B(b), .C_in(cin),
    .Sum_dut(sum_dut), .C_out_dut(co_dut),
    .Sum_verify(sum_ref), .C_out_verify(co_ref),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count), .first_fail_idx(ffi)
  );

  adder_checker_64 #(.NUM_VECTORS(2)) u_small (
    .clk(clk), .rst(rst), .start(start2),
    .A(a2), .B(b2), .C_in(cin2),
    .Sum_dut(sum2_ref), .C_out_dut(~co2_ref),
    .Sum_verify(sum2_ref), .C_out_verify(co2_ref),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_count(vc2), .first_fail_idx(ffi2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] step(input logic [63:0] x);
    step = x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
  endfunction

  // Queue the 256 expected vectors and final result for one run.
  task automatic build(input int flt);
    logic [63:0] l = step(SEED);
    logic [63:0] s;
    vec_t v;
    fin_t f;
    int e = 0, ff = -1;
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      v = '{64'd0, 64'd0, 1'b0};
      else if (i == 1) v = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
      else if (i == 2) v = '{64'hACE1_0000_0000_0001, 64'h0000_0001_ACE1_0000, 1'b1};
      else begin
        v = '{l, {l[31:0], l[63:32]}, l[0]};
        l = step(l);
      end
      exp_q.push_back(v);
      s = v.a + v.b + {63'd0, v.c};
      if (flt == 1 && s[5]) begin
        e++;
        if (ff < 0) ff = i;
      end
    end
    f = '{16'(e), 16'd256, (ff < 0) ? 16'hFFFF : 16'(ff), (e == 0)};
    fin_q.push_back(f);
  endtask

  task automatic monitor();
    logic [15:0] pv = 16'd0;
    logic pd = 1'b0, pd2 = 1'b0;
    vec_t e;
    fin_t f;
    forever begin
      @(negedge clk);
      if (vec_count == pv + 16'd1) begin
        if (exp_q.size() == 0) chk("vec_unexpected", 64'(vec_count), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("vec_a", a, e.a);
          chk("vec_b", b, e.b);
          chk("vec_cin", 64'(cin), 64'(e.c));
        end
      end
      if (done && !pd) begin
        if (fin_q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          f = fin_q.pop_front();
          chk("err_count", 64'(err_count), 64'(f.err));
          chk("vec_count", 64'(vec_count), 64'(f.vc));
          chk("first_fail", 64'(ffi), 64'(f.ffi));
          chk("pass", 64'(pass), 64'(f.pass));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
      if (done2 && !pd2) begin
        if (fin2_q.size() == 0) chk("done2_unexpected", 64'(done2), 64'd0);
        else begin
          f = fin2_q.pop_front();
          chk("s_err_count", 64'(err2), 64'(f.err));
          chk("s_vec_count", 64'(vc2), 64'(f.vc));
          chk("s_first_fail", 64'(ffi2), 64'(f.ffi));
          chk("s_pass", 64'(pass2), 64'(f.pass));
        end
      end
      pv = vec_count; pd = done; pd2 = done2;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_A"}, a, 64'd0);
    chk({tag, "_B"}, b, 64'd0);
    chk({tag, "_Cin"}, 64'(cin), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_err"}, 64'(err_count), 64'd0);
    chk({tag, "_vc"}, 64'(vec_count), 64'd0);
    chk({tag, "_ffi"}, 64'(ffi), 64'hFFFF);
  endtask

  // Pulse start, optionally pulse it again during SETTLE, and count cycles to done.
  task automatic run(input string tag, input bit extra_start);
    int n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_on"}, 64'(busy), 64'd1);
    chk({tag, "_done_clr"}, 64'(done), 64'd0);
    while (n < 4000) begin
      start = (extra_start && n == 2);
      @(negedge clk);
      n++;
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "_cycles"}, 64'(n), 64'd1536);
  endtask

  initial begin
    int n;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    chk("reset_busy2", 64'(busy2), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // correct adder, stray start in SETTLE
    build(0);
    run("run1", 1'b1);
    @(negedge clk);
    chk("done_hold", 64'(done), 64'd1);

    // bit-5 stuck-at-0, started from DONE
    fault = 1;
    build(1);
    run("run2", 1'b0);
    fault = 0;

    // reset mid-run at vec_count 100
    build(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec_count != 16'd100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vc100", 64'(vec_count), 64'd100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    exp_q.delete();
    fin_q.delete();
    @(negedge clk);
    chk("idle_after_rst", 64'(busy), 64'd0);

    // rerun from idx0 with identical vectors
    build(0);
    run("run3", 1'b0);

    // NUM_VECTORS=2 with inverted carry-out
    fin2_q.push_back('{16'd2, 16'd2, 16'd0, 1'b0});
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done2) break;
    end
    chk("s_cycles", 64'(n), 64'd12);
    repeat (2) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("fin_q_drained", 64'(fin_q.size() + fin2_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
